branch_predictor: RTL and testbench

- Direct-mapped branch target buffer with per-entry saturating direction counters, parametrised in depth and counter width.
- Looked up combinationally by the fetch-stage PC. Updated by the decode stage, where branches and jumps resolve.
- Replaces static not-taken fetch and lowers the flush penalty of taken branches and jumps.
- Predicted target feeds the PC select as an extra source.

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/sat_counter.sv | 48 ++++
 rtl/branch_predictor.sv | 154 +++++++++++++++
 tb/tb_branch_predictor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch target buffer: counter constants, the
// per-entry update opcode and table geometry helpers.
package bp_pkg;

  // Update applied to the indexed entry on a resolved branch or jump.
  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_ALLOC,
    UPD_INC,
    UPD_DEC,
    UPD_JUMP
  } upd_op_e;

  // Weakly-taken value: MSB set, all other bits clear.
  function automatic int unsigned ctr_wt(input int unsigned cb);
    return 32'd1 << (cb - 1);
  endfunction

  // Strongly-taken value: all bits set.
  function automatic int unsigned ctr_max(input int unsigned cb);
    return (32'd1 << cb) - 32'd1;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag holds everything above the index and the ignored byte offset.
  function automatic int unsigned calc_tag_w(input int unsigned addr_width,
                                             input int unsigned entries);
    return addr_width - $clog2(entries) - 2;
  endfunction

  // Geometry of the default configuration.
  localparam int unsigned BP_ADDR_WIDTH = 32;
  localparam int unsigned BP_ENTRIES    = 16;
  localparam int unsigned BP_IDX_W      = calc_idx_w(BP_ENTRIES);
  localparam int unsigned BP_TAG_W      = calc_tag_w(BP_ADDR_WIDTH, BP_ENTRIES);

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down direction counter for one table entry. Resets to
// weakly not-taken (WT-1). Priority: set_max > load_wt > inc > dec.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             set_max,
  input  logic             load_wt,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CtrMax = WIDTH'(ctr_max(WIDTH));
  localparam logic [WIDTH-1:0] CtrWt  = WIDTH'(ctr_wt(WIDTH));
  localparam logic [WIDTH-1:0] CtrRst = WIDTH'(ctr_wt(WIDTH) - 1);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Next count: load values first, then saturating step.
  always_comb begin
    cnt_d = cnt_q;
    if (set_max) begin
      cnt_d = CtrMax;
    end else if (load_wt) begin
      cnt_d = CtrWt;
    end else if (inc && (cnt_q != CtrMax)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CtrRst;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Combinational lookup from fetch, update from decode.
// Optional BP_STATS_EN adds free-running lookup/update/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned ENTRIES      = 16,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic                  update_is_jump,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_pred_taken,
  input  logic                  clear,
  output logic                  mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           stat_lookups,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = calc_idx_w(ENTRIES);
  localparam int unsigned TAG_W = calc_tag_w(ADDR_WIDTH, ENTRIES);

  logic [ENTRIES-1:0]      valid_q;
  logic [TAG_W-1:0]        tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0]   target_q [ENTRIES];
  logic [COUNTER_BITS-1:0] ctr      [ENTRIES];

  logic [IDX_W-1:0] look_idx, upd_idx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic             upd_hit;
  upd_op_e          upd_op;
  logic             mispredict_d, mispredict_q;

  // Byte offset bits never reach the table.
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[1:0], update_pc[1:0]};

  assign look_idx = lookup_pc[IDX_W+1:2];
  assign look_tag = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
  assign upd_idx  = update_pc[IDX_W+1:2];
  assign upd_tag  = update_pc[ADDR_WIDTH-1:IDX_W+2];

  // Lookup reads pre-update contents; no bypass from the update port.
  always_comb begin
    predict_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    predict_taken  = predict_hit && ctr[look_idx][COUNTER_BITS-1];
    predict_target = predict_hit ? target_q[look_idx] : '0;
  end

  // Decode the resolved instruction into an entry operation. A jump always
  // (re)writes the whole entry, which covers both hit and allocate.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_op  = UPD_NONE;
    if (update_valid && !clear) begin
      if (update_is_jump) begin
        upd_op = UPD_JUMP;
      end else if (upd_hit) begin
        upd_op = update_taken ? UPD_INC : UPD_DEC;
      end else if (update_taken) begin
        upd_op = UPD_ALLOC;
      end
    end
  end

  // Valid, tag and target storage; clear only drops valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (clear) begin
      valid_q <= '0;
    end else begin
      unique case (upd_op)
        UPD_ALLOC, UPD_JUMP: begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= update_target;
        end
        UPD_INC: target_q[upd_idx] <= update_target;
        default: ;
      endcase
    end
  end

  // One direction counter per entry.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (upd_idx == IDX_W'(i));
    sat_counter #(
      .WIDTH(COUNTER_BITS)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc    (sel && (upd_op == UPD_INC)),
      .dec    (sel && (upd_op == UPD_DEC)),
      .set_max(sel && (upd_op == UPD_JUMP)),
      .load_wt(sel && (upd_op == UPD_ALLOC)),
      .count  (ctr[i])
    );
  end

  // Misprediction is judged even when clear drops the update.
  assign mispredict_d = update_valid && ((update_taken || update_is_jump) != update_pred_taken);

  // Registered mispredict flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= mispredict_d;
    end
  end

  assign mispredict = mispredict_q;

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, updates_q, mispredicts_q;

  // Statistics counters wrap naturally and ignore clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_q     <= '0;
      updates_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      lookups_q     <= lookups_q + 32'd1;
      updates_q     <= updates_q + {31'd0, update_valid};
      mispredicts_q <= mispredicts_q + {31'd0, mispredict_d};
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_updates     = updates_q;
  assign stat_mispredicts = mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16 entries, 2-bit
// counters). Inputs change 1 time unit after a rising edge; outputs are
// sampled mid-cycle.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_is_jump;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic        clear;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups, stat_updates, stat_mispredicts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(
    .ADDR_WIDTH  (32),
    .ENTRIES     (16),
    .COUNTER_BITS(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .predict_hit      (predict_hit),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_is_jump   (update_is_jump),
    .update_target    (update_target),
    .update_pred_taken(update_pred_taken),
    .clear            (clear),
    .mispredict       (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a lookup and compare all three prediction outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit,
                      input logic exp_taken, input logic [31:0] exp_target);
    lookup_pc = pc;
    #1;
    check({tag, ".hit"}, {31'd0, predict_hit}, {31'd0, exp_hit});
    check({tag, ".taken"}, {31'd0, predict_taken}, {31'd0, exp_taken});
    check({tag, ".target"}, predict_target, exp_target);
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic taken, input logic jump,
                              input logic [31:0] target, input logic pred);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = taken;
    update_is_jump    = jump;
    update_target     = target;
    update_pred_taken = pred;
  endtask

  // Present one update for exactly one edge.
  task automatic do_update(input logic [31:0] pc, input logic taken, input logic jump,
                           input logic [31:0] target, input logic pred);
    drive_update(pc, taken, jump, target, pred);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic check_mp(input string tag, input logic exp);
    check(tag, {31'd0, mispredict}, {31'd0, exp});
  endtask

  localparam logic [31:0] PcA     = 32'h0040_0010;  // index 4
  localparam logic [31:0] PcAlias = 32'h0040_0410;  // index 4, other tag
  localparam logic [31:0] PcJ     = 32'h0040_0020;  // index 8
  localparam logic [31:0] PcN     = 32'h0040_0030;  // index 12

  initial begin
    rst = 1'b0;
    lookup_pc = PcA;
    update_valid = 1'b0;
    update_pc = '0;
    update_taken = 1'b0;
    update_is_jump = 1'b0;
    update_target = '0;
    update_pred_taken = 1'b0;
    clear = 1'b0;

    // Reset state.
    #12;
    look("reset", PcA, 1'b0, 1'b0, 32'h0);
    check_mp("reset.mp", 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    look("post_reset", PcA, 1'b0, 1'b0, 32'h0);

    // Allocate on a taken branch; same-cycle lookup still sees the old entry.
    drive_update(PcA, 1'b1, 1'b0, 32'h0040_0100, 1'b0);
    look("alloc.pre", PcA, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    check_mp("alloc.mp", 1'b1);
    look("alloc", PcA, 1'b1, 1'b1, 32'h0040_0100);

    // 2 -> 1 -> 0, target retained.
    do_update(PcA, 1'b0, 1'b0, 32'hdead_beef, 1'b1);
    check_mp("dec1.mp", 1'b1);
    look("dec1", PcA, 1'b1, 1'b0, 32'h0040_0100);
    do_update(PcA, 1'b0, 1'b0, 32'h0, 1'b0);
    check_mp("dec2.mp", 1'b0);
    look("dec2", PcA, 1'b1, 1'b0, 32'h0040_0100);

    // Saturate at 0: one more decrement then an increment must give 1 (not taken).
    do_update(PcA, 1'b0, 1'b0, 32'h0, 1'b0);
    look("dec3", PcA, 1'b1, 1'b0, 32'h0040_0100);
    do_update(PcA, 1'b1, 1'b0, 32'h0040_0200, 1'b0);
    check_mp("inc.mp", 1'b1);
    look("sat_zero_inc", PcA, 1'b1, 1'b0, 32'h0040_0200);

    // Alias replaces the entry with a fresh weakly-taken one.
    do_update(PcAlias, 1'b1, 1'b0, 32'h0040_0300, 1'b0);
    look("alias.old", PcA, 1'b0, 1'b0, 32'h0);
    look("alias.new", PcAlias, 1'b1, 1'b1, 32'h0040_0300);

    // Update and lookup same index in one cycle.
    drive_update(PcAlias, 1'b0, 1'b0, 32'h0, 1'b1);
    look("same.pre", PcAlias, 1'b1, 1'b1, 32'h0040_0300);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    check_mp("same.mp", 1'b1);
    look("same.post", PcAlias, 1'b1, 1'b0, 32'h0040_0300);

    // Jump allocates at MAX: one decrement stays taken, a second does not.
    do_update(PcJ, 1'b0, 1'b1, 32'h0040_1000, 1'b1);
    check_mp("jump.mp", 1'b0);
    look("jump", PcJ, 1'b1, 1'b1, 32'h0040_1000);
    do_update(PcJ, 1'b0, 1'b0, 32'h0, 1'b1);
    look("jump.dec1", PcJ, 1'b1, 1'b1, 32'h0040_1000);
    do_update(PcJ, 1'b0, 1'b0, 32'h0, 1'b1);
    look("jump.dec2", PcJ, 1'b1, 1'b0, 32'h0040_1000);

    // Not-taken conditional miss allocates nothing.
    do_update(PcN, 1'b0, 1'b0, 32'h0040_0400, 1'b1);
    check_mp("nt_miss.mp", 1'b1);
    look("nt_miss", PcN, 1'b0, 1'b0, 32'h0);

    // clear wins over a simultaneous update; mispredict still reported.
    clear = 1'b1;
    do_update(PcN, 1'b1, 1'b0, 32'h0040_0500, 1'b0);
    check_mp("clear.mp", 1'b1);
    look("clear.n", PcN, 1'b0, 1'b0, 32'h0);
    look("clear.alias", PcAlias, 1'b0, 1'b0, 32'h0);
    look("clear.j", PcJ, 1'b0, 1'b0, 32'h0);

    // Re-populate, then assert reset between edges with an update in flight.
    do_update(PcA, 1'b1, 1'b0, 32'h0040_0600, 1'b0);
    look("realloc", PcA, 1'b1, 1'b1, 32'h0040_0600);
    drive_update(PcA, 1'b1, 1'b1, 32'h0040_0700, 1'b0);
    rst = 1'b0;
    look("async_rst", PcA, 1'b0, 1'b0, 32'h0);
    check_mp("async_rst.mp", 1'b0);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    #2;
    rst = 1'b1;
    look("rel.a", PcA, 1'b0, 1'b0, 32'h0);
    look("rel.alias", PcAlias, 1'b0, 1'b0, 32'h0);
    check_mp("rel.mp", 1'b0);
`ifdef BP_STATS_EN
    check("stat.lookups", stat_lookups, 32'd0);
    check("stat.updates", stat_updates, 32'd0);
    check("stat.mispredicts", stat_mispredicts, 32'd0);
`endif
    @(posedge clk);
    #1;
    look("rel.edge", PcA, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
